// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage buffer.
//   pipe_state_e : buffer fill state (EMPTY / ONE / TWO)
//   OCC_W        : width of the occupancy count
//   occ_of()     : state -> occupancy encoding
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Number of entries held in a given state.
    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
        logic [OCC_W-1:0] occ;
        occ = OCC_W'(0);
        case (s)
            ONE:     occ = OCC_W'(1);
            TWO:     occ = OCC_W'(2);
            default: occ = OCC_W'(0);
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with synchronous load and clear (clear wins).
// Resets asynchronously to CLR_VAL.
//   clk, rst_n : clock, async active-low reset
//   load_i     : capture d_i on the next rising edge
//   clear_i    : force CLR_VAL on the next rising edge
//   d_i / q_o  : payload in / held payload out
import pipe_pkg::*;

module pipe_payload_reg #(
    parameter int unsigned   W       = 96,
    parameter logic [W-1:0]  CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next payload value.
    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = CLR_VAL;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    // Payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= CLR_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic two-entry pipeline register for instruction/PC pairs.
// A main register drives out_*; a skid register absorbs one beat while main
// is stalled, so in_ready is a pure register output with no path from
// out_ready. flush is synchronous and overrides everything.
//
// Optional build macro PIPE_ZERO_ON_FLUSH_EN: clear main and skid payloads
// (instr=0, pc=FLUSH_PC_VAL) whenever the buffer becomes/stays empty.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_instr, in_pc     : upstream payload
//   flush               : drop all held and incoming beats
//   out_valid/out_ready : downstream handshake
//   out_instr, out_pc   : held payload
//   occupancy           : entries held, 0..2
import pipe_pkg::*;

module pipe_stage_buf #(
    parameter int unsigned      INSTR_W      = 32,
    parameter int unsigned      PC_W         = 64,
    parameter logic [PC_W-1:0]  FLUSH_PC_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [OCC_W-1:0]   occupancy
);

    localparam int unsigned       PAY_W   = INSTR_W + PC_W;
    localparam logic [PAY_W-1:0]  PAY_CLR = {{INSTR_W{1'b0}}, FLUSH_PC_VAL};

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [OCC_W-1:0]  occ_q;

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic              pay_clr;

    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  main_d;
    logic [PAY_W-1:0]  main_q;
    logic [PAY_W-1:0]  skid_q;

    // in_ready_q is 0 in TWO, so an X on in_valid cannot reach in_fire there.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    assign in_pay = {in_instr, in_pc};
    assign main_d = main_from_skid ? skid_q : in_pay;

    // Next-state and load control.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        pay_clr        = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (out_fire) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush discards everything, including a beat offered this cycle.
        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end

`ifdef PIPE_ZERO_ON_FLUSH_EN
        // Empty buffer always presents a NOP bubble at FLUSH_PC_VAL.
        if (state_d == EMPTY) begin
            pay_clr = 1'b1;
        end
`endif
    end

    // State and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= OCC_W'(0);
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= occ_of(state_d);
        end
    end

    pipe_payload_reg #(
        .W       (PAY_W),
        .CLR_VAL (PAY_CLR)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (pay_clr),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_payload_reg #(
        .W       (PAY_W),
        .CLR_VAL (PAY_CLR)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (pay_clr),
        .d_i     (in_pay),
        .q_o     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occ_q;
    assign out_instr = main_q[PAY_W-1:PC_W];
    assign out_pc    = main_q[PC_W-1:0];

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a default-parameter instance and a narrow
// instance (INSTR_W=16, PC_W=32, FLUSH_PC_VAL=0x8000_0000) share stimulus
// and are both compared against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam logic [63:0] FLUSH_W = 64'h0;
    localparam logic [31:0] FLUSH_N = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        w_in_ready, w_out_valid;
    logic [31:0] w_out_instr;
    logic [63:0] w_out_pc;
    logic [1:0]  w_occ;

    logic        n_in_ready, n_out_valid;
    logic [15:0] n_out_instr;
    logic [31:0] n_out_pc;
    logic [1:0]  n_occ;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    beat_t model_q[$];

    pipe_stage_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_instr (w_out_instr),
        .out_pc    (w_out_pc),
        .occupancy (w_occ)
    );

    pipe_stage_buf #(
        .INSTR_W      (16),
        .PC_W         (32),
        .FLUSH_PC_VAL (FLUSH_N)
    ) dut_nar (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (n_in_ready),
        .in_instr  (in_instr[15:0]),
        .in_pc     (in_pc[31:0]),
        .flush     (flush),
        .out_valid (n_out_valid),
        .out_ready (out_ready),
        .out_instr (n_out_instr),
        .out_pc    (n_out_pc),
        .occupancy (n_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a FIFO of at most two beats, flush empties it.
    task automatic model_step(input logic v, input beat_t b, input logic ordy, input logic fl);
        logic ifire, ofire;
        ifire = v && (model_q.size() < 2);
        ofire = ordy && (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (ofire) void'(model_q.pop_front());
            if (ifire) model_q.push_back(b);
        end
    endtask

    task automatic check_outputs(input string tag);
        int unsigned n;
        n = model_q.size();
        check({tag, ".valid"},   64'(w_out_valid), 64'(n != 0));
        check({tag, ".ready"},   64'(w_in_ready),  64'(n < 2));
        check({tag, ".occ"},     64'(w_occ),       64'(n));
        check({tag, ".n_valid"}, 64'(n_out_valid), 64'(n != 0));
        check({tag, ".n_ready"}, 64'(n_in_ready),  64'(n < 2));
        check({tag, ".n_occ"},   64'(n_occ),       64'(n));
        if (n != 0) begin
            check({tag, ".instr"},   64'(w_out_instr), 64'(model_q[0].instr));
            check({tag, ".pc"},      w_out_pc,         model_q[0].pc);
            check({tag, ".n_instr"}, 64'(n_out_instr), 64'(model_q[0].instr[15:0]));
            check({tag, ".n_pc"},    64'(n_out_pc),    64'(model_q[0].pc[31:0]));
        end
`ifdef PIPE_ZERO_ON_FLUSH_EN
        else begin
            check({tag, ".z_instr"},   64'(w_out_instr), 64'h0);
            check({tag, ".z_pc"},      w_out_pc,         FLUSH_W);
            check({tag, ".z_n_instr"}, 64'(n_out_instr), 64'h0);
            check({tag, ".z_n_pc"},    64'(n_out_pc),    64'(FLUSH_N));
        end
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, check after the edge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] ins,
                         input logic [63:0] pc, input logic ordy, input logic fl);
        beat_t b;
        b.instr   = ins;
        b.pc      = pc;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_step(v, b, ordy, fl);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"},   64'(w_out_valid), 64'h0);
        check({tag, ".ready"},   64'(w_in_ready),  64'h1);
        check({tag, ".occ"},     64'(w_occ),       64'h0);
        check({tag, ".instr"},   64'(w_out_instr), 64'h0);
        check({tag, ".pc"},      w_out_pc,         FLUSH_W);
        check({tag, ".n_valid"}, 64'(n_out_valid), 64'h0);
        check({tag, ".n_instr"}, 64'(n_out_instr), 64'h0);
        check({tag, ".n_pc"},    64'(n_out_pc),    64'(FLUSH_N));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("reset");

        // Single beat, 1-cycle latency.
        cycle("first", 1'b1, 32'h00A00093, 64'h1000, 1'b1, 1'b0);
        cycle("drain1", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Back-to-back stream at full rate.
        for (int i = 0; i < 4; i++) begin
            cycle("stream", 1'b1, 32'h0000_0013 + 32'(i), 64'(4 * i), 1'b1, 1'b0);
        end
        cycle("stream_end", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure fills both entries, then drains in order.
        cycle("bp_a", 1'b1, 32'hAAAA_0001, 64'h100, 1'b0, 1'b0);
        cycle("bp_b", 1'b1, 32'hBBBB_0002, 64'h104, 1'b0, 1'b0);
        cycle("bp_hold", 1'b1, 32'hCCCC_0003, 64'h108, 1'b0, 1'b0);
        cycle("bp_d1", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle("bp_d2", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush while full with a beat offered; that beat must vanish.
        cycle("fl_a", 1'b1, 32'h1111_0001, 64'h10, 1'b0, 1'b0);
        cycle("fl_b", 1'b1, 32'h2222_0002, 64'h14, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h3333_0003, 64'h20, 1'b1, 1'b1);
        cycle("post_fl", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while holding one beat.
        cycle("ar_load", 1'b1, 32'h4444_0004, 64'h40, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        check_reset_state("async_rst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("ar_idle");
        cycle("ar_beat", 1'b1, 32'h5555_0005, 64'h50, 1'b1, 1'b0);
        cycle("ar_drain", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 600; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom,
                  {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
